// File: rtl/idp_sequencer_pkg.sv
// Shared definitions for the integer-datapath sequencer: widths, opcodes,
// write-back source codes and the FSM state encoding.
package idp_sequencer_pkg;
    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NREG = 8;
    localparam int OPW  = 4;

    localparam logic [OPW-1:0] OP_NOP       = 4'd0;
    localparam logic [OPW-1:0] OP_LDI       = 4'd1;
    localparam logic [OPW-1:0] OP_MOV       = 4'd2;
    localparam logic [OPW-1:0] OP_CLR       = 4'd3;
    localparam logic [OPW-1:0] OP_ALU_FIRST = 4'd4;

    // PASS_R shares the MOV code point; ALU functions occupy 4..15.
    localparam logic [OPW-1:0] ALU_PASS_R = 4'd2;

    localparam logic [1:0] W_SEL_ALU  = 2'd0;
    localparam logic [1:0] W_SEL_IMM  = 2'd1;
    localparam logic [1:0] W_SEL_ZERO = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_CLR
    } state_e;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [AW-1:0]  dst;
    } instr_t;

    function automatic logic [OPW-1:0] alu_code(input logic [OPW-1:0] op);
        case (op)
            OP_MOV:  alu_code = ALU_PASS_R;
            OP_LDI:  alu_code = '0;
            default: alu_code = op;
        endcase
    endfunction
endpackage

// File: rtl/idp_sequencer_if.sv
// Instruction handshake plus register-file/ALU control bundle of the sequencer.
interface idp_sequencer_if;
    import idp_sequencer_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [AW-1:0]  in_dst;
    logic [AW-1:0]  in_srcR;
    logic [AW-1:0]  in_srcS;
    logic [DW-1:0]  in_imm;

    logic           we;
    logic [AW-1:0]  W_Adr;
    logic [AW-1:0]  R_Adr;
    logic [AW-1:0]  S_Adr;
    logic [OPW-1:0] alu_op;
    logic [1:0]     w_sel;
    logic [DW-1:0]  imm_out;
    logic           busy;
    logic           done;

    modport master (
        output in_valid, in_op, in_dst, in_srcR, in_srcS, in_imm,
        input  in_ready, we, W_Adr, R_Adr, S_Adr, alu_op, w_sel, imm_out, busy, done
    );

    modport slave (
        input  in_valid, in_op, in_dst, in_srcR, in_srcS, in_imm,
        output in_ready, we, W_Adr, R_Adr, S_Adr, alu_op, w_sel, imm_out, busy, done
    );
endinterface

// File: rtl/idp_sequencer_clr.sv
// Register-address walker for CLR: load to zero, count up on enable,
// flag the last and second-to-last addresses. Never wraps.
module idp_sequencer_clr
    import idp_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          en_i,
    output logic [AW-1:0] cnt_o,
    output logic          last_o,
    output logic          nlast_o
);
    logic [AW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      cnt_q <= '0;
        else if (load_i) cnt_q <= '0;
        else if (en_i)   cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o   = cnt_q;
    assign last_o  = (cnt_q == AW'(NREG - 1));
    assign nlast_o = (cnt_q == AW'(NREG - 2));
endmodule

// File: rtl/idp_sequencer.sv
// Multi-cycle control FSM for the integer datapath: READ/EXEC/WB per
// instruction, plus a NREG-cycle CLR sweep. All control outputs are registered.
module idp_sequencer
    import idp_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    idp_sequencer_if.slave bus
);
    state_e         state_q, state_d;
    instr_t         instr_q, instr_d;
    logic           we_q, we_d;
    logic           done_q, done_d;
    logic [AW-1:0]  wadr_q, wadr_d;
    logic [AW-1:0]  radr_q, radr_d;
    logic [AW-1:0]  sadr_q, sadr_d;
    logic [OPW-1:0] alu_q, alu_d;
    logic [1:0]     wsel_q, wsel_d;
    logic [DW-1:0]  imm_q, imm_d;

    logic           cnt_load, cnt_en, cnt_last, cnt_nlast;
    logic [AW-1:0]  cnt;

    idp_sequencer_clr u_clr (
        .clk     (clk),
        .reset   (reset),
        .load_i  (cnt_load),
        .en_i    (cnt_en),
        .cnt_o   (cnt),
        .last_o  (cnt_last),
        .nlast_o (cnt_nlast)
    );

    // Next-output values are computed for the state being entered, so each
    // output register already holds the right value during that state.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        imm_d    = imm_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        wadr_d   = wadr_q;
        radr_d   = radr_q;
        sadr_d   = sadr_q;
        alu_d    = alu_q;
        wsel_d   = wsel_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    instr_d = '{op: bus.in_op, dst: bus.in_dst};
                    imm_d   = bus.in_imm;
                    if (bus.in_op == OP_CLR) begin
                        state_d  = S_CLR;
                        cnt_load = 1'b1;
                        we_d     = 1'b1;
                        wadr_d   = '0;
                        wsel_d   = W_SEL_ZERO;
                    end else begin
                        state_d = S_READ;
                        radr_d  = bus.in_srcR;
                        sadr_d  = bus.in_srcS;
                        done_d  = (bus.in_op == OP_NOP);
                    end
                end
            end
            S_READ: begin
                if (instr_q.op == OP_NOP) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                    alu_d   = alu_code(instr_q.op);
                    wsel_d  = (instr_q.op == OP_LDI) ? W_SEL_IMM : W_SEL_ALU;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                we_d    = 1'b1;
                wadr_d  = instr_q.dst;
                done_d  = 1'b1;
            end
            S_WB: state_d = S_IDLE;
            S_CLR: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    we_d   = 1'b1;
                    wadr_d = cnt + 1'b1;
                    done_d = cnt_nlast;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            imm_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            wadr_q  <= '0;
            radr_q  <= '0;
            sadr_q  <= '0;
            alu_q   <= '0;
            wsel_q  <= W_SEL_ALU;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            we_q    <= we_d;
            done_q  <= done_d;
            wadr_q  <= wadr_d;
            radr_q  <= radr_d;
            sadr_q  <= sadr_d;
            alu_q   <= alu_d;
            wsel_q  <= wsel_d;
        end
    end

    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.we       = we_q;
    assign bus.done     = done_q;
    assign bus.W_Adr    = wadr_q;
    assign bus.R_Adr    = radr_q;
    assign bus.S_Adr    = sadr_q;
    assign bus.alu_op   = alu_q;
    assign bus.w_sel    = wsel_q;
    assign bus.imm_out  = imm_q;
endmodule
